// File: rtl/misao_mem_pkg.sv
// Shared types and widths for the misao memory subsystem.
// Included by the RAM and by the top-level controller.
package misao_mem_pkg;

    localparam int MISAO_ADDR_W = 15;
    localparam int MISAO_DATA_W = 8;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } mem_state_t;

endpackage

// File: rtl/misao_ram.sv
// Byte RAM of 2^ADDR_W entries: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset so a reload can be partial.
module misao_ram
    import misao_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [MISAO_DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [MISAO_DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [MISAO_DATA_W-1:0] mem_r [DEPTH];

    // Write port: commits on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: combinational, so a same-edge write is seen only afterwards.
    always_comb begin
        rdata = mem_r[raddr];
    end

endmodule

// File: rtl/misao_mem_sys.sv
// misao memory subsystem: preloads RAM from a byte-stream loader while the core
// is held in reset, then serves core reads/writes with sticky error flags.
module misao_mem_sys
    import misao_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LOAD_BASE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_enable_read,
    input  logic                    mem_enable_write,
    input  logic [MISAO_ADDR_W-1:0] mem_addr,
    input  logic                    mem_rw,
    input  logic [MISAO_DATA_W-1:0] mem_data_out,
    output logic [MISAO_DATA_W-1:0] mem_data_in,
    input  logic                    ld_valid,
    input  logic [MISAO_DATA_W-1:0] ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    output logic                    core_rst,
    output logic                    load_ovf,
    output logic                    oob_err
);

    localparam logic [ADDR_W-1:0] BASE_PTR = LOAD_BASE[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    mem_state_t              state_r;
    logic [ADDR_W-1:0]       ptr_r;
    logic                    core_rst_r;
    logic                    load_ovf_r;
    logic                    oob_err_r;

    logic                    oob_s;
    logic                    ram_we_s;
    logic [ADDR_W-1:0]       ram_waddr_s;
    logic [MISAO_DATA_W-1:0] ram_wdata_s;
    logic [MISAO_DATA_W-1:0] ram_rdata_s;
    logic                    unused_s;

    // The direction hint carries no information beyond the two strobes.
    assign unused_s = mem_rw;

    // Any address bit at or above ADDR_W means the access misses the RAM.
    assign oob_s    = (mem_addr >> ADDR_W) != {MISAO_ADDR_W{1'b0}};

    assign ld_ready = (state_r == LOAD);
    assign core_rst = core_rst_r;
    assign load_ovf = load_ovf_r;
    assign oob_err  = oob_err_r;

    // Write-port mux: loader owns the RAM in LOAD, the core owns it in RUN.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ptr_r;
        ram_wdata_s = ld_data;
        case (state_r)
            LOAD: begin
                ram_we_s = ld_valid;
            end
            RUN: begin
                ram_we_s    = mem_enable_write & ~oob_s;
                ram_waddr_s = mem_addr[ADDR_W-1:0];
                ram_wdata_s = mem_data_out;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Core read data: zero unless in RUN with an in-range read strobe.
    always_comb begin
        if ((state_r == RUN) && mem_enable_read && !oob_s) begin
            mem_data_in = ram_rdata_s;
        end else begin
            mem_data_in = {MISAO_DATA_W{1'b0}};
        end
    end

    // Control FSM with registered core reset and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= LOAD;
            ptr_r      <= BASE_PTR;
            core_rst_r <= 1'b1;
            load_ovf_r <= 1'b0;
            oob_err_r  <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    core_rst_r <= 1'b1;
                    if (ld_valid) begin
                        if (ptr_r == LAST_PTR) begin
                            // Final RAM byte: leave regardless, pointer never wraps.
                            state_r <= RELEASE;
                            if (!ld_last) begin
                                load_ovf_r <= 1'b1;
                            end
                        end else begin
                            ptr_r <= ptr_r + PTR_ONE;
                            if (ld_last) begin
                                state_r <= RELEASE;
                            end
                        end
                    end
                end
                RELEASE: begin
                    state_r    <= RUN;
                    core_rst_r <= 1'b0;
                end
                RUN: begin
                    core_rst_r <= 1'b0;
                    if ((mem_enable_read || mem_enable_write) && oob_s) begin
                        oob_err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= LOAD;
                    core_rst_r <= 1'b1;
                end
            endcase
        end
    end

    misao_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (mem_addr[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

endmodule

// File: tb/tb_misao_mem_sys.sv
// Scoreboard bench for misao_mem_sys: random stimulus against a byte-array
// reference model; a negedge monitor checks every core read.
module tb_misao_mem_sys;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enable_read = 1'b0;
    logic        mem_enable_write = 1'b0;
    logic [14:0] mem_addr = 15'd0;
    logic        mem_rw = 1'b0;
    logic [7:0]  mem_data_out = 8'd0;
    logic [7:0]  mem_data_in;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'd0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        core_rst;
    logic        load_ovf;
    logic        oob_err;

    always #5 clk = ~clk;

    misao_mem_sys #(.ADDR_W(AW), .LOAD_BASE(0)) dut (
        .clk(clk), .rst(rst),
        .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .core_rst(core_rst), .load_ovf(load_ovf), .oob_err(oob_err)
    );

    // Reference model: plain byte array plus load bookkeeping.
    logic [7:0] ref_mem [DEPTH];
    bit         ref_known [DEPTH];
    int         ref_ptr;
    bit         ref_loading;
    bit         ref_ovf;
    bit         ref_oob;

    typedef struct {
        bit          dc;
        logic [7:0]  val;
        logic [14:0] addr;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read strobe seen mid-cycle consumes one expected byte.
    always @(negedge clk) begin
        if (rst && mem_enable_read) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h at addr %h, no expectation queued", mem_data_in, mem_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!e.dc) begin
                    n_chk++;
                    if (mem_data_in !== e.val) begin
                        n_fail++;
                        $display("FAIL rd_data addr %h: got %h expected %h at %0t", e.addr, mem_data_in, e.val, $time);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b0;
        mem_enable_read = 1'b0;
        mem_enable_write = 1'b0;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        #1;
        chk("rst_core_rst", {7'd0, core_rst}, 8'd1);
        chk("rst_ld_ready", {7'd0, ld_ready}, 8'd1);
        chk("rst_load_ovf", {7'd0, load_ovf}, 8'd0);
        chk("rst_oob_err", {7'd0, oob_err}, 8'd0);
        ref_ptr = 0;
        ref_loading = 1'b1;
        ref_ovf = 1'b0;
        ref_oob = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic load_stream(input logic [7:0] data[$], input bit with_last, input bit gaps);
        for (int i = 0; i < data.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                // Idle loader cycle; core strobes here must be ignored.
                ld_valid = 1'b0;
                mem_enable_read = 1'b1;
                mem_enable_write = 1'b1;
                if ($urandom_range(0, 1) == 1)
                    mem_addr = 15'($urandom_range(0, DEPTH - 1));
                else
                    mem_addr = 15'($urandom_range(DEPTH, 32767));
                mem_data_out = 8'($urandom);
                exp_q.push_back('{dc: 1'b0, val: 8'h00, addr: mem_addr});
                tick();
                mem_enable_read = 1'b0;
                mem_enable_write = 1'b0;
            end
            ld_valid = 1'b1;
            ld_data = data[i];
            ld_last = with_last && (i == data.size() - 1);
            chk("load_ld_ready", {7'd0, ld_ready}, {7'd0, ref_loading});
            tick();
            if (ref_loading) begin
                ref_mem[ref_ptr] = data[i];
                ref_known[ref_ptr] = 1'b1;
                if (ld_last) begin
                    ref_loading = 1'b0;
                end else if (ref_ptr == DEPTH - 1) begin
                    ref_ovf = 1'b1;
                    ref_loading = 1'b0;
                end else begin
                    ref_ptr++;
                end
            end
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic check_release();
        chk("release_ld_ready", {7'd0, ld_ready}, 8'd0);
        chk("release_core_rst", {7'd0, core_rst}, 8'd1);
        chk("release_load_ovf", {7'd0, load_ovf}, {7'd0, ref_ovf});
        tick();
        chk("run_core_rst", {7'd0, core_rst}, 8'd0);
        chk("run_ld_ready", {7'd0, ld_ready}, 8'd0);
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [14:0] addr, input logic [7:0] wdata);
        bit in_range;
        in_range = (addr < 15'(DEPTH));
        mem_enable_read = rd;
        mem_enable_write = wr;
        mem_addr = addr;
        mem_data_out = wdata;
        mem_rw = 1'($urandom);
        if (rd) begin
            if (in_range)
                exp_q.push_back('{dc: !ref_known[addr[7:0]], val: ref_mem[addr[7:0]], addr: addr});
            else
                exp_q.push_back('{dc: 1'b0, val: 8'h00, addr: addr});
        end
        chk("oob_err_pre", {7'd0, oob_err}, {7'd0, ref_oob});
        tick();
        if (wr && in_range) begin
            ref_mem[addr[7:0]] = wdata;
            ref_known[addr[7:0]] = 1'b1;
        end
        if ((rd || wr) && !in_range) ref_oob = 1'b1;
        mem_enable_read = 1'b0;
        mem_enable_write = 1'b0;
    endtask

    initial begin
        logic [7:0] s[$];
        logic [14:0] a;

        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        tick();
        apply_reset();

        // Basic three-byte load with continuous valid.
        s = '{8'h11, 8'h22, 8'h33};
        load_stream(s, 1'b1, 1'b0);
        check_release();
        for (int i = 0; i < 3; i++) run_op(1'b1, 1'b0, 15'(i), 8'h00);

        // Reset from RUN, gapped reload, then directed RUN traffic.
        apply_reset();
        s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load_stream(s, 1'b1, 1'b1);
        check_release();
        for (int i = 0; i < 8; i++) run_op(1'b1, 1'b0, 15'(i), 8'h00);
        run_op(1'b1, 1'b0, 15'h0001, 8'h00);
        run_op(1'b0, 1'b1, 15'h0080, 8'hA5);
        run_op(1'b1, 1'b0, 15'h0080, 8'h00);
        run_op(1'b0, 1'b1, 15'h0081, 8'h3C);
        run_op(1'b1, 1'b1, 15'h0081, 8'h5B);
        run_op(1'b1, 1'b0, 15'h0081, 8'h00);
        run_op(1'b1, 1'b0, 15'h0100, 8'h00);
        chk("oob_set_after_edge", {7'd0, oob_err}, 8'd1);
        run_op(1'b0, 1'b1, 15'h4000, 8'h77);
        run_op(1'b1, 1'b0, 15'h0000, 8'h00);
        tick();
        tick();
        chk("oob_sticky", {7'd0, oob_err}, 8'd1);

        // Randomized RUN traffic.
        apply_reset();
        s.delete();
        for (int i = 0; i < 20; i++) s.push_back(8'($urandom));
        load_stream(s, 1'b1, 1'b1);
        check_release();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 85) a = 15'($urandom_range(0, DEPTH - 1));
            else a = 15'($urandom_range(DEPTH, 32767));
            run_op(1'($urandom), 1'($urandom), a, 8'($urandom));
        end
        chk("rand_oob_err", {7'd0, oob_err}, {7'd0, ref_oob});

        // Overflow: a full RAM of bytes with no last marker.
        apply_reset();
        s.delete();
        for (int i = 0; i < DEPTH; i++) s.push_back(8'($urandom));
        load_stream(s, 1'b0, 1'b0);
        chk("ovf_flag", {7'd0, load_ovf}, 8'd1);
        check_release();
        run_op(1'b1, 1'b0, 15'h00FF, 8'h00);
        run_op(1'b1, 1'b0, 15'h0000, 8'h00);
        run_op(1'b1, 1'b0, 15'h0100, 8'h00);
        chk("ovf_sticky", {7'd0, load_ovf}, 8'd1);
        chk("ovf_oob", {7'd0, oob_err}, 8'd1);

        // Reset mid-load, then a fresh three-byte stream.
        apply_reset();
        s = '{8'hAA, 8'hBB};
        load_stream(s, 1'b0, 1'b0);
        apply_reset();
        s = '{8'hC1, 8'hC2, 8'hC3};
        load_stream(s, 1'b1, 1'b0);
        check_release();
        for (int i = 0; i < 5; i++) run_op(1'b1, 1'b0, 15'(i), 8'h00);
        chk("final_load_ovf", {7'd0, load_ovf}, 8'd0);
        chk("final_oob_err", {7'd0, oob_err}, 8'd0);

        tick();
        tick();
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
